// File: rtl/hour_display.sv
// Two-digit multiplexed 7-segment hour display with binary-to-BCD split, anti-ghost gap and adjust blink.
// Optional HOUR12_EN: 12-hour display with PM indicator (default build is 24-hour, pm held at 0).
module hour_display #(
  parameter int SCAN_DIV  = 1000,
  parameter int BLINK_DIV = 250
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [5:0] hours,
  input  logic       adjust,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       pm
);

  // state | meaning
  // ONES  | ones digit enabled (an = 10)
  // GAP_T | one blank cycle before tens digit
  // TENS  | tens digit enabled (an = 01)
  // GAP_O | one blank cycle before ones digit; reset state
  typedef enum logic [1:0] {ONES, GAP_T, TENS, GAP_O} scan_state_t;

  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  scan_state_t   state, state_next;
  logic [SW-1:0] scan_cnt, scan_cnt_next;
  logic [BW-1:0] blink_cnt, blink_cnt_next;
  logic          blink_off, blink_off_next;
  logic [5:0]    hour_q;
  logic [6:0]    seg_next;
  logic [1:0]    an_next;
  logic          pm_next;
  logic          in_range;
  logic          gap_entry;
  logic [4:0]    disp;
  logic [4:0]    ones_w;
  logic [3:0]    tens_d;
  logic [3:0]    ones_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      hour_q    <= 6'd0;
      state     <= GAP_O;
      scan_cnt  <= '0;
      blink_cnt <= '0;
      blink_off <= 1'b0;
      seg       <= SEG_BLANK;
      an        <= 2'b11;
      pm        <= 1'b0;
    end else begin
      hour_q    <= hours;
      state     <= state_next;
      scan_cnt  <= scan_cnt_next;
      blink_cnt <= blink_cnt_next;
      blink_off <= blink_off_next;
      seg       <= seg_next;
      an        <= an_next;
      pm        <= pm_next;
    end
  end

  // Hour value as shown on the display, then its tens/ones split.
  always_comb begin
    in_range = (hour_q <= 6'd23);
    disp     = 5'd0;
    pm_next  = 1'b0;
    if (in_range) begin
`ifdef HOUR12_EN
      if (hour_q == 6'd0)
        disp = 5'd12;
      else if (hour_q <= 6'd12)
        disp = hour_q[4:0];
      else
        disp = hour_q[4:0] - 5'd12;
      pm_next = (hour_q >= 6'd12);
`else
      disp = hour_q[4:0];
`endif
    end
    if (disp >= 5'd20) begin
      tens_d = 4'd2;
      ones_w = disp - 5'd20;
    end else if (disp >= 5'd10) begin
      tens_d = 4'd1;
      ones_w = disp - 5'd10;
    end else begin
      tens_d = 4'd0;
      ones_w = disp;
    end
    ones_d = ones_w[3:0];
  end

  always_comb begin
    state_next     = state;
    scan_cnt_next  = scan_cnt;
    blink_cnt_next = blink_cnt;
    blink_off_next = blink_off;
    gap_entry      = 1'b0;
    seg_next       = SEG_BLANK;
    an_next        = 2'b11;

    case (state)
      ONES: begin
        if (scan_cnt == SCAN_LAST) begin
          state_next    = GAP_T;
          scan_cnt_next = '0;
          gap_entry     = 1'b1;
        end else begin
          scan_cnt_next = scan_cnt + SW'(1);
        end
      end
      GAP_T: begin
        state_next    = TENS;
        scan_cnt_next = '0;
      end
      TENS: begin
        if (scan_cnt == SCAN_LAST) begin
          state_next    = GAP_O;
          scan_cnt_next = '0;
          gap_entry     = 1'b1;
        end else begin
          scan_cnt_next = scan_cnt + SW'(1);
        end
      end
      default: begin
        state_next    = ONES;
        scan_cnt_next = '0;
      end
    endcase

    // Counters stay cleared outside adjust so every adjust session starts visible.
    if (!adjust) begin
      blink_cnt_next = '0;
      blink_off_next = 1'b0;
    end else if (gap_entry) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt_next = '0;
        blink_off_next = ~blink_off;
      end else begin
        blink_cnt_next = blink_cnt + BW'(1);
      end
    end

    // Decode from the upcoming state so an and seg switch on the same edge.
    case (state_next)
      ONES: begin
        an_next  = 2'b10;
        seg_next = in_range ? seg7(ones_d) : SEG_DASH;
        if (blink_off)
          seg_next = SEG_BLANK;
      end
      TENS: begin
        an_next  = 2'b01;
        seg_next = in_range ? seg7(tens_d) : SEG_DASH;
        if (blink_off)
          seg_next = SEG_BLANK;
      end
      default: begin
        an_next  = 2'b11;
        seg_next = SEG_BLANK;
      end
    endcase
  end

endmodule
